// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Purpose: bundles the three request/response groups that meet at the shared
// byte-wide RAM port.
//   fetch_* : 4-byte instruction read requests and responses
//   lsb_*   : byte/half/word load and store requests and responses
//   ram_*   : single 8-bit synchronous RAM port (read data lags address by 1)
//
// Modports:
//   slave  : the arbiter (accepts requests, drives the RAM port)
//   master : the requesters plus RAM model (drive requests, provide ram_out)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  // instruction fetch channel
  logic        fetch_req_valid;
  logic [31:0] fetch_pc;
  logic        fetch_req_ready;
  logic        fetch_resp_valid;
  logic [31:0] fetch_resp_inst;
  logic [31:0] fetch_resp_pc;

  // load/store buffer channel
  logic        lsb_req_valid;
  logic        lsb_we;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_req_ready;
  logic        lsb_resp_valid;
  logic [31:0] lsb_resp_data;

  // byte-wide RAM port
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_in;
  logic [7:0]  ram_out;

  modport slave (
    input  fetch_req_valid, fetch_pc,
    output fetch_req_ready, fetch_resp_valid, fetch_resp_inst, fetch_resp_pc,
    input  lsb_req_valid, lsb_we, lsb_size, lsb_addr, lsb_wdata,
    output lsb_req_ready, lsb_resp_valid, lsb_resp_data,
    output ram_rw, ram_addr, ram_in,
    input  ram_out
  );

  modport master (
    output fetch_req_valid, fetch_pc,
    input  fetch_req_ready, fetch_resp_valid, fetch_resp_inst, fetch_resp_pc,
    output lsb_req_valid, lsb_we, lsb_size, lsb_addr, lsb_wdata,
    input  lsb_req_ready, lsb_resp_valid, lsb_resp_data,
    input  ram_rw, ram_addr, ram_in,
    output ram_out
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares one 8-bit RAM port between the instruction fetcher and the
// load/store buffer. One request (byte, half or word) is accepted at a time
// and expanded into little-endian per-byte RAM cycles. Read bytes are
// assembled into a 32-bit word; stores return an acknowledge pulse.
// Reads are abandoned on flush; stores always run to completion.
//
// Sequence for an N-byte request accepted at cycle T:
//   ACCESS T+1..T+N, DRAIN T+N+1 (last read byte lands), RESP T+N+2.
//
// Ports:
//   clk_in   : clock
//   rst_in   : asynchronous active-low reset
//   rdy_in   : global ready; low freezes all state and blocks RAM writes
//   flush_in : pipeline flush (aborts reads, blocks new acceptance)
//   bus      : mem_arbiter_if.slave (fetch, LSB and RAM signal groups)
//
// Parameters:
//   STARVE_LIMIT : consecutive LSB grants tolerated while fetch waits
//
// Build option:
//   MEM_ARB_FAIRNESS_EN : when defined, fetch is guaranteed a grant after
//   STARVE_LIMIT back-to-back LSB grants made while it was waiting. When
//   undefined, the LSB has strict priority.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The starvation counter is 3 bits wide; a limit outside 1..7 could never
  // be reached.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must lie in 1..7");
  end

  // Index of the last byte of a request: byte -> 0, half -> 1, word -> 3.
  // Size code 3 is treated as a word.
  function automatic logic [1:0] size_to_last(input logic [1:0] size);
    case (size)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;        // byte currently addressed
  logic [1:0]  last_q, last_d;      // N-1
  logic        own_lsb_q, own_lsb_d; // 1 = LSB owns the port, 0 = fetch
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
  logic [2:0]  starve_q, starve_d;
`endif

  logic        fetch_turn;
  logic        lsb_win;
  logic        fetch_win;
  logic        accept_ok;
  logic        read_abort;
  logic [31:0] cur_addr;
  logic [1:0]  prev_idx;

  assign cur_addr   = addr_q + 32'(idx_q);
  assign prev_idx   = idx_q - 2'd1;
  // Requests are only taken while running, unflushed and out of reset.
  assign accept_ok  = rdy_in && !flush_in && rst_in;
  // A flush only ever kills reads; a committed store must finish.
  assign read_abort = flush_in && !we_q;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_turn = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
    fetch_turn = (starve_q == STARVE_MAX) && bus.fetch_req_valid
                 && bus.lsb_req_valid;
`endif
    lsb_win   = bus.lsb_req_valid && !fetch_turn;
    fetch_win = bus.fetch_req_valid && !lsb_win;
  end

  // -------------------------------------------------------------------------
  // Next-state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    own_lsb_d = own_lsb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifdef MEM_ARB_FAIRNESS_EN
    starve_d  = starve_q;
`endif

    bus.fetch_req_ready  = 1'b0;
    bus.lsb_req_ready    = 1'b0;
    bus.fetch_resp_valid = 1'b0;
    bus.lsb_resp_valid   = 1'b0;
    bus.ram_rw           = 1'b1;
    bus.ram_addr         = 32'h0;
    bus.ram_in           = 8'h0;

    case (state_q)
      IDLE: begin
        if (accept_ok && (lsb_win || fetch_win)) begin
          bus.lsb_req_ready   = lsb_win;
          bus.fetch_req_ready = fetch_win;
          own_lsb_d = lsb_win;
          we_d      = lsb_win && bus.lsb_we;
          addr_d    = lsb_win ? bus.lsb_addr : bus.fetch_pc;
          last_d    = lsb_win ? size_to_last(bus.lsb_size) : 2'd3;
          wdata_d   = lsb_win ? bus.lsb_wdata : 32'h0;
          // Unused upper bytes of short loads must read back as zero.
          rdata_d   = 32'h0;
          idx_d     = 2'd0;
          state_d   = ACCESS;
`ifdef MEM_ARB_FAIRNESS_EN
          if (fetch_win) begin
            starve_d = 3'd0;
          end else if (bus.fetch_req_valid) begin
            starve_d = starve_q + 3'd1;
          end
`endif
        end
      end

      ACCESS: begin
        bus.ram_addr = cur_addr;
        if (we_q) begin
          // A stalled write cycle is held off by forcing a read.
          bus.ram_rw = !rdy_in;
          bus.ram_in = wdata_q[{idx_q, 3'b000} +: 8];
        end
        if (rdy_in) begin
          if (read_abort) begin
            state_d = IDLE;
          end else begin
            // ram_out carries the byte addressed in the previous cycle.
            if (!we_q && idx_q != 2'd0) begin
              rdata_d[{prev_idx, 3'b000} +: 8] = bus.ram_out;
            end
            if (idx_q == last_q) begin
              state_d = DRAIN;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
      end

      DRAIN: begin
        if (rdy_in) begin
          if (read_abort) begin
            state_d = IDLE;
          end else begin
            if (!we_q) begin
              rdata_d[{last_q, 3'b000} +: 8] = bus.ram_out;
            end
            state_d = RESP;
          end
        end
      end

      RESP: begin
        if (rdy_in) begin
          if (!read_abort) begin
            bus.lsb_resp_valid   = own_lsb_q;
            bus.fetch_resp_valid = !own_lsb_q;
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response data is held in the latches between transactions.
  assign bus.fetch_resp_inst = rdata_q;
  assign bus.fetch_resp_pc   = addr_q;
  assign bus.lsb_resp_data   = we_q ? 32'h0 : rdata_q;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      last_q    <= 2'd0;
      own_lsb_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
`ifdef MEM_ARB_FAIRNESS_EN
      starve_q  <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      own_lsb_q <= own_lsb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
`ifdef MEM_ARB_FAIRNESS_EN
      starve_q  <= starve_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter: a 256-byte RAM model indexed by the low
// address byte, one task per scenario, inline comparisons and a summary line.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush_in;

  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  // RAM model: synchronous read (data one cycle after address), write when
  // ram_rw is low. A preload port lets the bench seed bytes while idle.
  logic [7:0] mem [256];
  logic       pl_we;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.ram_rw == 1'b0) mem[bus.ram_addr[7:0]] <= bus.ram_in;
    bus.ram_out <= mem[bus.ram_addr[7:0]];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    next_cycle();
    pl_we = 1'b0;
  endtask

  task automatic drop_requests();
    bus.fetch_req_valid = 1'b0;
    bus.lsb_req_valid   = 1'b0;
  endtask

  task automatic lsb_request(input logic we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wd);
    bus.lsb_req_valid = 1'b1;
    bus.lsb_we        = we;
    bus.lsb_size      = size;
    bus.lsb_addr      = addr;
    bus.lsb_wdata     = wd;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    #1;
    vec++; if (bus.ram_rw !== 1'b1) begin errs++; $display("FAIL reset_ram_rw got %0h want 1", bus.ram_rw); end
    vec++; if (bus.ram_addr !== 32'h0) begin errs++; $display("FAIL reset_ram_addr got %0h want 0", bus.ram_addr); end
    vec++; if (bus.ram_in !== 8'h0) begin errs++; $display("FAIL reset_ram_in got %0h want 0", bus.ram_in); end
    vec++; if (bus.fetch_resp_inst !== 32'h0 || bus.lsb_resp_data !== 32'h0)
      begin errs++; $display("FAIL reset_data got inst=%0h lsb=%0h want 0", bus.fetch_resp_inst, bus.lsb_resp_data); end
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b1;
    @(negedge clk);
    vec++; if ({bus.fetch_req_ready, bus.lsb_req_ready, bus.fetch_resp_valid, bus.lsb_resp_valid} !== 4'b0)
      begin errs++; $display("FAIL reset_handshake got %b want 0000",
        {bus.fetch_req_ready, bus.lsb_req_ready, bus.fetch_resp_valid, bus.lsb_resp_valid}); end
    next_cycle();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_fetch_read();
    poke(8'h00, 8'h13); poke(8'h01, 8'h05); poke(8'h02, 8'h50); poke(8'h03, 8'h00);
    bus.fetch_req_valid = 1'b1; bus.fetch_pc = 32'h100;
    @(negedge clk);
    vec++; if (bus.fetch_req_ready !== 1'b1) begin errs++; $display("FAIL fetch_accept got %0h want 1", bus.fetch_req_ready); end
    next_cycle();
    bus.fetch_req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        vec++; if (bus.ram_addr !== 32'h100 + 32'(k - 1) || bus.ram_rw !== 1'b1)
          begin errs++; $display("FAIL fetch_addr k=%0d got %0h rw=%0h want %0h rw=1", k, bus.ram_addr, bus.ram_rw, 32'h100 + 32'(k - 1)); end
      end
      vec++; if (bus.fetch_resp_valid !== (k == 6))
        begin errs++; $display("FAIL fetch_resp_valid k=%0d got %0h want %0h", k, bus.fetch_resp_valid, (k == 6)); end
      if (k == 6) begin
        vec++; if (bus.fetch_resp_inst !== 32'h00500513) begin errs++; $display("FAIL fetch_inst got %0h want 00500513", bus.fetch_resp_inst); end
        vec++; if (bus.fetch_resp_pc !== 32'h100) begin errs++; $display("FAIL fetch_pc got %0h want 100", bus.fetch_resp_pc); end
      end
      next_cycle();
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_store_load();
    lsb_request(1'b1, 2'd0, 32'h20, 32'h000000AB);
    @(negedge clk);
    vec++; if (bus.lsb_req_ready !== 1'b1) begin errs++; $display("FAIL store_accept got %0h want 1", bus.lsb_req_ready); end
    next_cycle();
    drop_requests();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vec++; if (bus.ram_rw !== 1'b0 || bus.ram_addr !== 32'h20 || bus.ram_in !== 8'hAB)
          begin errs++; $display("FAIL store_write got rw=%0h addr=%0h in=%0h want rw=0 addr=20 in=ab", bus.ram_rw, bus.ram_addr, bus.ram_in); end
      end else begin
        vec++; if (bus.ram_rw !== 1'b1) begin errs++; $display("FAIL store_rw k=%0d got %0h want 1", k, bus.ram_rw); end
      end
      vec++; if (bus.lsb_resp_valid !== (k == 3)) begin errs++; $display("FAIL store_resp k=%0d got %0h want %0h", k, bus.lsb_resp_valid, (k == 3)); end
      if (k == 3) begin
        vec++; if (bus.lsb_resp_data !== 32'h0) begin errs++; $display("FAIL store_data got %0h want 0", bus.lsb_resp_data); end
      end
      next_cycle();
    end
    poke(8'h21, 8'hFF);
    lsb_request(1'b0, 2'd1, 32'h20, 32'h0);
    @(negedge clk);
    vec++; if (bus.lsb_req_ready !== 1'b1) begin errs++; $display("FAIL load_accept got %0h want 1", bus.lsb_req_ready); end
    next_cycle();
    drop_requests();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      vec++; if (bus.lsb_resp_valid !== (k == 4)) begin errs++; $display("FAIL load_resp k=%0d got %0h want %0h", k, bus.lsb_resp_valid, (k == 4)); end
      if (k == 4) begin
        vec++; if (bus.lsb_resp_data !== 32'h0000FFAB) begin errs++; $display("FAIL load_data got %0h want 0000ffab", bus.lsb_resp_data); end
      end
      next_cycle();
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_simultaneous();
    logic g [5];
    int n = 0;
    bus.fetch_req_valid = 1'b1; bus.fetch_pc = 32'h100;
    lsb_request(1'b0, 2'd0, 32'h20, 32'h0);
    for (int c = 0; c < 60 && n < 5; c++) begin
      @(negedge clk);
      if (bus.lsb_req_ready === 1'b1) begin g[n] = 1'b1; n++; end
      else if (bus.fetch_req_ready === 1'b1) begin g[n] = 1'b0; n++; end
      next_cycle();
      if (n == 5) drop_requests();
    end
    drop_requests();
    vec++; if (n != 5) begin errs++; $display("FAIL arb_grant_count got %0d want 5", n); end
    for (int i = 0; i < n; i++) begin
      logic want;
`ifdef MEM_ARB_FAIRNESS_EN
      want = (i != 4);
`else
      want = 1'b1;
`endif
      vec++; if (g[i] !== want) begin errs++; $display("FAIL arb_grant_%0d got lsb=%0h want lsb=%0h", i, g[i], want); end
    end
    repeat (10) next_cycle();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush_read();
    int pulses = 0;
    bus.fetch_req_valid = 1'b1; bus.fetch_pc = 32'h100;
    @(negedge clk);
    vec++; if (bus.fetch_req_ready !== 1'b1) begin errs++; $display("FAIL flush_rd_accept got %0h want 1", bus.fetch_req_ready); end
    next_cycle();
    drop_requests();
    for (int k = 1; k <= 8; k++) begin
      flush_in = (k == 2);
      @(negedge clk);
      if (bus.fetch_resp_valid === 1'b1) pulses++;
      if (k == 3) begin
        vec++; if (bus.ram_addr !== 32'h0 || bus.ram_rw !== 1'b1)
          begin errs++; $display("FAIL flush_rd_idle got addr=%0h rw=%0h want addr=0 rw=1", bus.ram_addr, bus.ram_rw); end
      end
      next_cycle();
    end
    vec++; if (pulses != 0) begin errs++; $display("FAIL flush_rd_resp got %0d pulses want 0", pulses); end
    // no acceptance while flush is high in IDLE
    flush_in = 1'b1;
    lsb_request(1'b0, 2'd0, 32'h20, 32'h0);
    @(negedge clk);
    vec++; if (bus.lsb_req_ready !== 1'b0) begin errs++; $display("FAIL flush_idle_accept got %0h want 0", bus.lsb_req_ready); end
    next_cycle();
    drop_requests();
    flush_in = 1'b0;
    next_cycle();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush_store();
    logic [31:0] wa [8];
    logic [7:0]  wd [8];
    int n = 0;
    int resp_k = -1;
    logic [31:0] resp_data = 32'hFFFFFFFF;
    lsb_request(1'b1, 2'd2, 32'h40, 32'h44332211);
    @(negedge clk);
    vec++; if (bus.lsb_req_ready !== 1'b1) begin errs++; $display("FAIL flush_st_accept got %0h want 1", bus.lsb_req_ready); end
    next_cycle();
    drop_requests();
    for (int k = 1; k <= 8; k++) begin
      flush_in = (k >= 2 && k <= 6);
      @(negedge clk);
      if (bus.ram_rw === 1'b0 && n < 8) begin wa[n] = bus.ram_addr; wd[n] = bus.ram_in; n++; end
      if (bus.lsb_resp_valid === 1'b1) begin resp_k = k; resp_data = bus.lsb_resp_data; end
      next_cycle();
    end
    flush_in = 1'b0;
    vec++; if (n != 4) begin errs++; $display("FAIL flush_st_count got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      vec++; if (wa[i] !== 32'h40 + 32'(i) || wd[i] !== 8'(8'h11 * (i + 1)))
        begin errs++; $display("FAIL flush_st_byte%0d got %0h/%0h want %0h/%0h", i, wa[i], wd[i], 32'h40 + 32'(i), 8'(8'h11 * (i + 1))); end
    end
    vec++; if (resp_k != 6 || resp_data !== 32'h0)
      begin errs++; $display("FAIL flush_st_resp got cycle %0d data %0h want cycle 6 data 0", resp_k, resp_data); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall();
    logic [31:0] wa [8];
    logic [7:0]  wd [8];
    int wk [8];
    int n = 0;
    int stalled_writes = 0;
    int resp_k = -1;
    logic [7:0] want_d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int want_k [4] = '{1, 5, 6, 7};
    lsb_request(1'b1, 2'd2, 32'h50, 32'hDDCCBBAA);
    @(negedge clk);
    vec++; if (bus.lsb_req_ready !== 1'b1) begin errs++; $display("FAIL stall_accept got %0h want 1", bus.lsb_req_ready); end
    next_cycle();
    drop_requests();
    for (int k = 1; k <= 12; k++) begin
      rdy_in = !(k >= 2 && k <= 4);
      @(negedge clk);
      if (bus.ram_rw === 1'b0) begin
        if (rdy_in == 1'b0) stalled_writes++;
        if (n < 8) begin wa[n] = bus.ram_addr; wd[n] = bus.ram_in; wk[n] = k; n++; end
      end
      if (bus.lsb_resp_valid === 1'b1) resp_k = k;
      next_cycle();
    end
    rdy_in = 1'b1;
    vec++; if (stalled_writes != 0) begin errs++; $display("FAIL stall_writes_while_low got %0d want 0", stalled_writes); end
    vec++; if (n != 4) begin errs++; $display("FAIL stall_count got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      vec++; if (wa[i] !== 32'h50 + 32'(i) || wd[i] !== want_d[i] || wk[i] != want_k[i])
        begin errs++; $display("FAIL stall_byte%0d got %0h/%0h@%0d want %0h/%0h@%0d", i, wa[i], wd[i], wk[i], 32'h50 + 32'(i), want_d[i], want_k[i]); end
    end
    vec++; if (resp_k != 9) begin errs++; $display("FAIL stall_resp got cycle %0d want 9", resp_k); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_addr_wrap();
    logic [31:0] want_a [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03); poke(8'h01, 8'h04);
    lsb_request(1'b0, 2'd2, 32'hFFFFFFFE, 32'h0);
    @(negedge clk);
    vec++; if (bus.lsb_req_ready !== 1'b1) begin errs++; $display("FAIL wrap_accept got %0h want 1", bus.lsb_req_ready); end
    next_cycle();
    drop_requests();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        vec++; if (bus.ram_addr !== want_a[k - 1]) begin errs++; $display("FAIL wrap_addr k=%0d got %0h want %0h", k, bus.ram_addr, want_a[k - 1]); end
      end
      if (k == 6) begin
        vec++; if (bus.lsb_resp_valid !== 1'b1 || bus.lsb_resp_data !== 32'h04030201)
          begin errs++; $display("FAIL wrap_resp got v=%0h d=%0h want v=1 d=04030201", bus.lsb_resp_valid, bus.lsb_resp_data); end
      end
      next_cycle();
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    bus.fetch_req_valid = 1'b1; bus.fetch_pc = 32'h100;
    @(negedge clk);
    vec++; if (bus.fetch_req_ready !== 1'b1) begin errs++; $display("FAIL rstmid_accept got %0h want 1", bus.fetch_req_ready); end
    next_cycle();
    drop_requests();
    next_cycle();
    vec++; if (bus.ram_addr !== 32'h101) begin errs++; $display("FAIL rstmid_pre_addr got %0h want 101", bus.ram_addr); end
    rst_in = 1'b0;
    #1;
    vec++; if (bus.ram_rw !== 1'b1 || bus.ram_addr !== 32'h0 || bus.ram_in !== 8'h0)
      begin errs++; $display("FAIL rstmid_ram got rw=%0h addr=%0h in=%0h want 1/0/0", bus.ram_rw, bus.ram_addr, bus.ram_in); end
    vec++; if (bus.fetch_resp_pc !== 32'h0 || bus.fetch_resp_inst !== 32'h0 || bus.lsb_resp_data !== 32'h0)
      begin errs++; $display("FAIL rstmid_data got pc=%0h inst=%0h lsb=%0h want 0", bus.fetch_resp_pc, bus.fetch_resp_inst, bus.lsb_resp_data); end
    repeat (2) next_cycle();
    rst_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vec++; if (bus.fetch_resp_valid !== 1'b0 || bus.ram_addr !== 32'h0)
        begin errs++; $display("FAIL rstmid_after k=%0d got v=%0h addr=%0h want 0/0", k, bus.fetch_resp_valid, bus.ram_addr); end
      next_cycle();
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    pl_we = 1'b0; pl_addr = 8'h0; pl_data = 8'h0;
    bus.fetch_req_valid = 1'b0; bus.fetch_pc = 32'h0;
    bus.lsb_req_valid = 1'b0; bus.lsb_we = 1'b0; bus.lsb_size = 2'd0;
    bus.lsb_addr = 32'h0; bus.lsb_wdata = 32'h0;
    test_reset();
    test_fetch_read();
    test_store_load();
    test_simultaneous();
    test_flush_read();
    test_flush_store();
    test_stall();
    test_addr_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial memory arbiter and sequencer that shares the single 8-bit RAM port between the instruction fetcher and the load/store buffer (LSB). It accepts one word, half or byte request at a time, expands it into per-byte RAM cycles (little-endian), and returns assembled read data or a store acknowledge. It handles pipeline flushes, where reads abort and committed stores always complete.

## Interface
- `STARVE_LIMIT`, 4: consecutive LSB grants allowed while fetch waits. Used only with `MEM_ARB_FAIRNESS_EN`.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset. Asynchronous and active-low.
- `rdy_in` in 1: global ready. Low freezes all state.
- `flush_in` in 1: ROB clear-up / mispredict flush.
- `fetch_req_valid` in 1: fetch request.
- `fetch_pc` in 32: fetch address (4-byte read).
- `fetch_req_ready` out 1: fetch request accepted this cycle.
- `fetch_resp_valid` out 1: instruction ready (one-cycle pulse).
- `fetch_resp_inst` out 32: instruction word.
- `fetch_resp_pc` out 32: address of `fetch_resp_inst`.
- `lsb_req_valid` in 1: LSB request.
- `lsb_we` in 1: 1 = store, 0 = load.
- `lsb_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `lsb_addr` in 32: byte address.
- `lsb_wdata` in 32: store data, low bytes used.
- `lsb_req_ready` out 1: LSB request accepted this cycle.
- `lsb_resp_valid` out 1: load data / store done (one-cycle pulse).
- `lsb_resp_data` out 32: zero-extended raw load bytes. Sign extension is done by the LSB. Value is 0 for stores.
- `ram_rw` out 1: 1 = read, 0 = write.
- `ram_addr` out 32: RAM byte address.
- `ram_in` out 8: write byte.
- `ram_out` in 8: read byte, valid the cycle after its address.

## Operation
- States: IDLE, ACCESS, DRAIN, RESP.
- **IDLE**
  - `*_req_ready` is asserted combinationally for the winning valid requester, when `rdy_in`=1 and `flush_in`=0.
  - On acceptance, latch requester, addr, N (1/2/4), write flag, data. Set idx=0 and go to ACCESS.
- **Arbitration (default):** LSB has fixed priority over fetch.
- **ACCESS**
  - Drive `ram_addr`=addr+idx (mod 2^32).
  - Reads drive `ram_rw`=1. Stores drive `ram_rw`=0 and `ram_in`=wdata[8·idx+7:8·idx].
  - For idx≥1, capture `ram_out` into byte idx−1.
  - idx increments each cycle. After idx=N−1, go to DRAIN.
- **DRAIN**
  - Capture the final byte N−1 (reads).
  - `ram_rw`=1.
  - Go to RESP.
- **RESP**
  - Pulse the owner's `*_resp_valid`; data is held stable.
  - Go to IDLE.
  - No new request is accepted in RESP.
- **Outside a store's ACCESS cycles:** `ram_rw`=1, `ram_in`=0, `ram_addr`=0 in IDLE.
- **`flush_in`=1**
  - Read in ACCESS/DRAIN/RESP: abort to IDLE next cycle. No resp pulse; read bytes are discarded.
  - Store in progress: unaffected. It completes and pulses `lsb_resp_valid`.
  - In IDLE, no request is accepted during flush.
- **`rdy_in`=0:** state, idx, latches and the fairness counter are frozen. `ram_rw` is forced to 1. `*_resp_valid` and `*_req_ready` are gated low.
- **Reset:** all state goes to IDLE and all registers clear to 0 immediately. Reset values of outputs: `ram_rw`=1, `ram_addr`=0, `ram_in`=0, all ready/valid=0, all data outputs 0.

## Timing
- Acceptance at cycle T (edge ending T).
- ACCESS occupies T+1..T+N.
- DRAIN is T+N+1.
- RESP is T+N+2.
- Fetch: response 6 cycles after accept.
- LSB word/half/byte: response 6 / 4 / 3 cycles after accept.
- Earliest next acceptance: T+N+3. Peak throughput is one request per N+3 cycles.
- Store bytes hit RAM at T+1..T+N in ascending address order.

## Configuration
- Macro: `MEM_ARB_FAIRNESS_EN`.
- **Defined**
  - A 3-bit counter increments on each LSB grant made while `fetch_req_valid`=1.
  - When the counter equals `STARVE_LIMIT` and both requesters are valid, fetch wins and the counter clears.
  - A fetch grant clears the counter. The counter is frozen by `rdy_in`=0 and cleared by reset.
- **Undefined:** strict LSB priority. Fetch may starve.

## Test plan
- **Fetch read:** RAM[0x100..0x103]=13,05,50,00. Fetch req pc=0x100 → `fetch_resp_valid` 6 cycles after accept, inst=0x00500513, pc=0x100.
- **Byte store then half load**
  - Store: LSB store size 0 addr 0x20 wdata 0xAB → one write cycle, `ram_rw`=0, addr 0x20, `ram_in`=0xAB; resp after 3 cycles.
  - Load: LSB load size 1 addr 0x20 with RAM[0x21]=0xFF → data=0x0000FFAB.
- **Simultaneous requests:** both valid in IDLE → LSB granted. With `MEM_ARB_FAIRNESS_EN`, `STARVE_LIMIT`=4 and both held valid → grants LSB×4 then fetch.
- **Flush during reads and stores**
  - Fetch read: flush asserted 2 cycles into it → no `fetch_resp_valid`, IDLE next cycle, `ram_rw`=1.
  - Word store: flush during its second byte → all 4 bytes written, `lsb_resp_valid` pulses.
- **Stall and reset**
  - Stall: `rdy_in` low 3 cycles mid word store → no writes while low, same byte resumes, total bytes written = 4.
  - Reset: `rst_in` low mid-access → outputs at reset values immediately.
- **Address wrap:** word load at 0xFFFFFFFE → `ram_addr` sequence FFFFFFFE, FFFFFFFF, 0, 1.
